// File: rtl/p_to_s_pkg.sv
// Shared definitions for the parallel-to-serial converter: default width,
// FSM state type and the counter-width helper.
package p_to_s_pkg;

  localparam int DEFAULT_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to hold the values 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/p_to_s_word_fifo2.sv
// Two-entry word FIFO with synchronous push/pop and full/empty flags.
// The head word is always visible on dout; pushes on full and pops on
// empty are ignored so the occupancy can never wrap.
module word_fifo2
  import p_to_s_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage: write the slot addressed by the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/p_to_s.sv
// Parallel-to-serial converter: words enter through a two-entry FIFO and
// leave LSB first, one bit per accepted downstream handshake, with
// last_out flagging the final bit of each word.
module p_to_s
  import p_to_s_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         ready_in,
  output logic         valid_out,
  output logic         data_out,
  output logic         last_out,
  input  logic         ready_out
);

  localparam int            CW       = clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  shift_reg;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          fifo_full;
  logic          fifo_empty;
  logic [W-1:0]  fifo_head;
  logic          push;
  logic          pop;
  logic          bit_xfer;
  logic          at_last;

  // ready_in depends only on registers; armed keeps it low until the
  // first edge after reset release.
  assign ready_in = armed & ~fifo_full;
  assign push     = valid_in & ready_in;
  assign bit_xfer = (state == SHIFT) & ready_out;
  assign at_last  = (cnt == LAST_CNT);
  // Load a new word when idle, or straight after the last bit goes out.
  assign pop      = ~fifo_empty & ((state == IDLE) | (bit_xfer & at_last));

  word_fifo2 #(.W(W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Input-side enable: set once the first clock after reset arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: stay in SHIFT across words when one is waiting.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = SHIFT;
      SHIFT:   if (bit_xfer && at_last && fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shifter and bit counter; both hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (pop) begin
      shift_reg <= fifo_head;
      cnt       <= '0;
    end else if (bit_xfer) begin
      if (at_last) begin
        shift_reg <= '0;
        cnt       <= '0;
      end else begin
        shift_reg <= shift_reg >> 1;
        cnt       <= cnt + CW'(1);
      end
    end
  end

  // Output decode from the registered state and shifter.
  always_comb begin
    valid_out = (state == SHIFT);
    data_out  = shift_reg[0];
    last_out  = (state == SHIFT) && at_last;
  end

endmodule

// File: tb/tb_p_to_s.sv
// Bench for p_to_s: directed scenarios plus randomized traffic, checked
// every cycle against a word-queue reference model and a loopback receiver.
module tb_p_to_s;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready_out = 1'b0;
  logic         ready_in;
  logic         valid_out;
  logic         data_out;
  logic         last_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: words waiting, word being sent, bit position.
  logic [W-1:0] m_q[$];
  logic [W-1:0] sent_q[$];
  logic [W-1:0] m_cur = '0;
  logic         m_busy = 1'b0;
  int           m_idx = 0;
  logic         m_init = 1'b0;
  logic [W-1:0] rx_word = '0;
  int           rx_cnt = 0;
  int           rx_words = 0;
  logic         take_word, take_bit, done_word;
  logic [W-1:0] exp_word;

  always #5 clk = ~clk;

  p_to_s #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, plus the loopback deserializer.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      sent_q.delete();
      m_busy = 1'b0;
      m_idx  = 0;
      m_init = 1'b0;
      rx_cnt = 0;
    end else begin
      take_word = valid_in && m_init && (m_q.size() < 2);
      take_bit  = m_busy && ready_out;
      if (valid_out && ready_out) begin
        if (rx_cnt < W) rx_word[rx_cnt] = data_out;
        rx_cnt++;
        if (last_out) begin
          check("rx_len", rx_cnt, W);
          exp_word = (sent_q.size() > 0) ? sent_q.pop_front() : ~rx_word;
          check("loopback_word", rx_word, exp_word);
          rx_words++;
          rx_cnt = 0;
        end
      end
      done_word = take_bit && (m_idx == W - 1);
      if ((!m_busy || done_word) && (m_q.size() > 0)) begin
        m_cur  = m_q.pop_front();
        m_idx  = 0;
        m_busy = 1'b1;
      end else if (done_word) begin
        m_busy = 1'b0;
      end else if (take_bit) begin
        m_idx++;
      end
      if (take_word) begin
        m_q.push_back(data_in);
        sent_q.push_back(data_in);
      end
      m_init = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("ready_in", ready_in, m_init && (m_q.size() < 2));
      check("valid_out", valid_out, m_busy);
      if (m_busy) begin
        check("data_out", data_out, m_cur[m_idx]);
        check("last_out", last_out, m_idx == W - 1);
      end else begin
        check("last_out_idle", last_out, 1'b0);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    valid_in = 1'b1;
    data_in = w;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      guard++;
    end
    #1 valid_in = 1'b0;
    check("push_accept", acc, 1'b1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((valid_out || m_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", valid_out, 1'b0);
  endtask

  logic exp29 [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp33 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int   start_words;
  int   cyc;

  initial begin
    // Reset state.
    #2;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_data_out", data_out, 1'b0);
    check("rst_last_out", last_out, 1'b0);
    check("rst_ready_in", ready_in, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", ready_in, 1'b0);
    @(negedge clk);
    check("ready_after_edge", ready_in, 1'b1);

    // Single word, literal LSB-first sequence.
    ready_out = 1'b1;
    @(posedge clk); #1;
    push_word(6'b101101);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("single_bit", data_out, exp29[i]);
      check("single_valid", valid_out, 1'b1);
      check("single_last", last_out, i == 5);
    end
    @(negedge clk);
    check("single_end_valid", valid_out, 1'b0);

    // Back-to-back words: 12 contiguous bits.
    @(posedge clk); #1;
    push_word(6'h3F);
    push_word(6'h00);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b_valid", valid_out, 1'b1);
      check("b2b_bit", data_out, i < 6);
      check("b2b_last", last_out, (i == 5) || (i == 11));
    end
    wait_idle();

    // Backpressure at bit 2 of 6'b010101, FIFO fills behind it.
    @(posedge clk); #1;
    push_word(6'b010101);
    repeat (3) @(posedge clk);
    #1 ready_out = 1'b0;
    push_word(6'h2A);
    push_word(6'h15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_bit", data_out, 1'b1);
      check("bp_hold_last", last_out, 1'b0);
      check("bp_ready_in", ready_in, 1'b0);
    end
    @(posedge clk); #1 ready_out = 1'b1;
    wait_idle();

    // Three words offered while stalled; third must wait.
    @(posedge clk); #1 ready_out = 1'b0;
    fork
      begin
        push_word(6'h11);
        push_word(6'h22);
        push_word(6'h33);
      end
      begin
        repeat (8) @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    wait_idle();

    // Reset mid-word during bit 3.
    @(posedge clk); #1;
    push_word(6'b111111);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid_out, 1'b0);
    check("midrst_data", data_out, 1'b0);
    check("midrst_last", last_out, 1'b0);
    check("midrst_ready", ready_in, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_low", ready_in, 1'b0);
    @(negedge clk);
    check("rel_ready_high", ready_in, 1'b1);
    check("rel_no_bits", valid_out, 1'b0);
    @(posedge clk); #1;
    push_word(6'b000011);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_bit", data_out, exp33[i]);
    end
    wait_idle();

    // Randomized loopback traffic: at least 100 words.
    start_words = rx_words;
    cyc = 0;
    while (rx_words < start_words + 100 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      ready_out = ($urandom_range(0, 3) != 0);
      valid_in  = ($urandom_range(0, 2) != 0);
      data_in   = W'($urandom);
    end
    check("loopback_count", rx_words >= start_words + 100, 1'b1);
    valid_in = 1'b0;
    ready_out = 1'b1;
    wait_idle();
    @(negedge clk);
    check("all_words_out", sent_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/p_to_s.md
P_TO_S -- requirements
Module: p_to_s

Interface
REQ-001 Parameter: W, default 6, parallel word width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assertion and release handling per REQ-024, active-low.
REQ-004 Port: valid_in  input  1  upstream word valid.
REQ-005 Port: data_in  input  W  upstream parallel word.
REQ-006 Port: ready_in  output  1  block can accept a word this cycle.
REQ-007 Port: valid_out  output  1  serial bit valid; drives a downstream serial-to-parallel stage's valid input.
REQ-008 Port: data_out  output  1  serial bit, LSB first.
REQ-009 Port: last_out  output  1  high with bit W-1 of each word.
REQ-010 Port: ready_out  input  1  downstream accepts the current bit.

Function
REQ-011 Word handshake: word transfer occurs on a clk edge where valid_in=1 and ready_in=1; otherwise data_in is ignored.
REQ-012 Bit handshake: bit transfer occurs on a clk edge where valid_out=1 and ready_out=1.
REQ-013 Input buffer: 2-entry FIFO of W-bit words; ready_in = (occupancy < 2), derived from registered state only.
REQ-014 FSM states: IDLE (valid_out=0, no word in shifter) and SHIFT (valid_out=1).
REQ-015 IDLE -> SHIFT: when FIFO is non-empty, the head word is popped into the shifter at the next edge; data_out=word[0], cnt=0, valid_out=1.
REQ-016 First-bit latency: a word pushed into an empty FIFO with FSM in IDLE at edge N appears as valid_out=1, data_out=bit0 after edge N+1.
REQ-017 In SHIFT, on each bit transfer with cnt<W-1: data_out advances to the next higher bit, cnt increments.
REQ-018 On bit transfer with cnt=W-1: if FIFO non-empty, next word loads immediately (no bubble, SHIFT retained); else valid_out<=0, FSM -> IDLE.
REQ-019 last_out=1 exactly when valid_out=1 and cnt=W-1.
REQ-020 Stall: while ready_out=0, data_out, last_out, valid_out, cnt and shifter contents hold unchanged.
REQ-021 Simultaneous push and pop in one edge: occupancy unchanged, FIFO order preserved.
REQ-022 Push when FIFO full is impossible (ready_in=0); words are never dropped or duplicated.
REQ-023 Sustained throughput with ready_out=1 and valid_in=1: one bit per clk, continuous valid_out.

Reset
REQ-024 rst_n=0 asynchronously forces: valid_out=0, data_out=0, last_out=0, FSM=IDLE, cnt=0, FIFO empty, ready_in=0.
REQ-025 ready_in rises to 1 at the first clk edge after rst_n deasserts.
REQ-026 Reset asserted mid-word aborts the word; no partial bits are emitted after release.

Structure
REQ-027 Shared package holds: default width constant (6), FSM state typedef {IDLE, SHIFT}, counter width function clog2(W).
REQ-028 FIFO is a sub-module, word_fifo2: 2-entry, synchronous push/pop, full/empty outputs; p_to_s instantiates it once.

Verification
REQ-029 Single word: push 6'b101101 with ready_out=1 -> data_out sequence 1,0,1,1,0,1 over 6 cycles, last_out on 6th, then valid_out=0.
REQ-030 Back-to-back: push 6'h3F then 6'h00 consecutively -> 12 contiguous valid bits (six 1s, six 0s), no gap, last_out on bits 6 and 12.
REQ-031 Backpressure: ready_out=0 for 5 cycles at bit 2 of 6'b010101 -> data_out holds 1, cnt holds, stream resumes correctly; ready_in drops after two more pushes.
REQ-032 Full FIFO: three words offered back-to-back while stalled -> third is held off (ready_in=0) until first word is loaded into the shifter; all three serialized in order.
REQ-033 Reset mid-word: rst_n low during bit 3 -> outputs zero immediately; next word after release starts at bit 0.
REQ-034 Loopback: p_to_s output chained into the team's 6-bit serial-to-parallel stage, 100 random words -> identical words received in order.
